// File: rtl/uart_echo_ctrl.sv
// Byte-echo responder between UART_Rx and UART_Tx: received bytes are queued and replayed in order.
// Optional build macro UART_ECHO_CASE_EN swaps the case of ASCII letters on the way out.
module uart_echo_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_val,
  input  logic [7:0]    rx_data,
  input  logic          busy,
  output logic          tx_val,
  output logic [7:0]    tx_data,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          rx_val_q;
  logic          wr_pend_q, wr_pend_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          ovf_q, ovf_d;
  logic          tx_val_q, tx_val_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    mem_q [DEPTH];

  logic          rx_rise;
  logic          pop;
  logic          wr_accept;

  function automatic logic [7:0] echo_map(input logic [7:0] b);
`ifdef UART_ECHO_CASE_EN
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  // A held rx_val produces a single write because only the low-to-high transition is captured.
  assign rx_rise   = rx_val & ~rx_val_q;
  assign pop       = (state_q == IDLE) && !empty_q && !busy;
  // When full, a write is only safe if the head leaves in the same cycle.
  assign wr_accept = wr_pend_q && (!full_q || pop);

  // NOTE: combinational next-state logic uses blocking assignments with a default for
  // every signal first, so no latch can be inferred on an unassigned path.
  always_comb begin
    state_d   = state_q;
    wr_pend_d = rx_rise;
    wr_data_d = rx_rise ? rx_data : wr_data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tx_val_d  = tx_val_q;
    tx_data_d = tx_data_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (wr_pend_q && !wr_accept) ovf_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    if (wr_accept && !pop)      count_d = count_q + CW'(1);
    else if (!wr_accept && pop) count_d = count_q - CW'(1);

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = echo_map(mem_q[rd_ptr_q]);
          tx_val_d  = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // UART_Tx only looks at tx_val on its own strobe, so hold it until busy confirms.
        if (busy) begin
          tx_val_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!busy) state_d = IDLE;
      end
      default: begin
        tx_val_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rx_val_q  <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_data_q <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_val_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rx_val_q  <= rx_val;
      wr_pend_q <= wr_pend_d;
      wr_data_q <= wr_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= (count_d == DEPTH_C);
      empty_q   <= (count_d == '0);
      ovf_q     <= ovf_d;
      tx_val_q  <= tx_val_d;
      tx_data_q <= tx_data_d;
    end
  end

  // NOTE: the byte store has no reset; cleared pointers and count mean stale entries are never read.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data_q;
  end

  assign tx_val     = tx_val_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/uart_echo_ctrl.md
# uart_echo_ctrl

Byte-echo responder placed between a `UART_Rx` and a `UART_Tx` on the same system clock. Every byte received (`rx_val`/`rx_data`) is queued in a small FIFO and handed back to the transmitter one at a time using the `tx_val`/`busy` handshake. This makes the design a self-contained loopback endpoint that answers whatever a host transmits. Overruns are flagged rather than stalling the receiver.

## Interface

- `DEPTH`, default 8: FIFO depth in bytes. Must be a power of two, ≥ 2.
- `CW`, default 4: count width, equal to log2(`DEPTH`)+1.

Ports:

- `clk`  in  1: system clock, the same clock as `UART_Tx`/`UART_Rx`.
- `rst`  in  1: reset, asynchronous and active-low.
- `rx_val`  in  1: byte-valid from `UART_Rx`. May be a single-cycle pulse or a held level.
- `rx_data`  in  8: received byte. Valid while `rx_val` is high.
- `busy`  in  1: `UART_Tx` busy flag.
- `tx_val`  out  1: send request to `UART_Tx`.
- `tx_data`  out  8: byte to send. Stable while `tx_val` is high or `busy` is high.
- `fifo_count`  out  `CW`: number of bytes queued.
- `fifo_full`  out  1: `fifo_count == DEPTH`.
- `fifo_empty`  out  1: `fifo_count == 0`.
- `overflow`  out  1: sticky flag. Set when a byte is dropped; cleared only by reset.

## Operation

- **Receive:** a byte is accepted on the rising edge of `rx_val`, detected as registered previous value low and current value high. Exactly one write occurs per edge, so a held `rx_val` does not re-write.
- **Write acceptance:**
  - If not full, the byte is written at the write pointer.
  - If full and a pop occurs in the same cycle, the write is accepted and the count is unchanged.
  - If full with no pop, the byte is dropped and `overflow` is set to 1.
- **Pointers:** `log2(DEPTH)` bits, wrapping modulo `DEPTH`. The count is tracked separately.
- **Transmit FSM** (states `IDLE`, `REQ`, `DRAIN`):
  - `IDLE`: if `!fifo_empty && !busy`, pop the head into `tx_data`, set `tx_val`=1, and go to `REQ`.
  - `REQ`: hold `tx_val`=1 until `busy`==1 is sampled, then set `tx_val`=0 and go to `DRAIN`. `UART_Tx` samples `tx_val` only on its `pulse_tx` strobe, so `tx_val` is held high however many cycles that takes.
  - `DRAIN`: wait for `busy`==0, then go to `IDLE`.
- **Ordering:** bytes are echoed in receive order, with no duplication and no loss except overflow drops.

## Timing

- **Reset values:** `tx_val`=0, `tx_data`=8'h00, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0. FSM is in `IDLE`, pointers are 0, edge register is 0.
- **Reset mid-operation:** all state clears immediately (asynchronously), including queued bytes. `tx_val` drops without waiting for `busy`.
- **Write latency:** `fifo_count` updates on the edge after the one where the `rx_val` rise is sampled.
- **Echo latency:** with an empty FIFO, `IDLE` state and `busy`=0, `tx_val` goes high 2 clock edges after the `rx_val` rise is sampled.
- **Gap between bytes:** at least one `IDLE` cycle separates `busy` falling and the next `tx_val` rising.
- **Flags:** all flags are registered, with no combinational input-to-output paths.

## Configuration

- `UART_ECHO_CASE_EN`:
  - **Defined:** ASCII letters are case-swapped on the pop path. 0x41–0x5A has 0x20 added; 0x61–0x7A has 0x20 subtracted. All other bytes pass unchanged. No extra latency is introduced.
  - **Undefined:** bytes are echoed verbatim.

## Test plan

- **Single echo:** reset, then an `rx_val` pulse with 0xAC and `busy` low → `tx_val` high 2 edges later with `tx_data`=0xAC. `tx_val` is held until `busy` rises, and `fifo_count` returns to 0.
- **Held level:** `rx_val` held high for 10 cycles with 0x55 → exactly one write (`fifo_count`=1) and exactly one echo.
- **Overflow:** `busy` forced high and 9 distinct bytes sent with `DEPTH`=8 → `fifo_full`=1 and `overflow`=1. After `busy` is released, the first 8 bytes are echoed in order and the 9th is absent.
- **Full plus pop:** FIFO full, and a new byte arrives in the same cycle `IDLE` pops → the byte is accepted, the count stays at 8, and `overflow` stays 0.
- **Reset mid-send:** `rst` asserted low while in `REQ` → `tx_val`=0 and `fifo_count`=0 immediately. After release, no stale echo occurs.
- **Case swap:** with `UART_ECHO_CASE_EN` defined, 0x61 is echoed as 0x41 and 0x31 as 0x31. Without the macro, 0x61 is echoed as 0x61.
